game_flow_ctrl: RTL and testbench

Game sequencer for the HDMI Flappy Bird design, running in the 25 MHz pixel clock domain between the debounced jump key, the picture generator and the score/beeper outputs. It owns the game state machine (idle, play, dying, game over), derives a once-per-frame tick from vsync, and schedules bird flaps to frame boundaries. It also maintains the 20-bit score fed to the 7-segment driver and arbitrates three sound events onto the single beeper request.

---
 rtl/game_flow_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game sequencer for the HDMI Flappy Bird design: frame tick from vsync, jump key
// synchroniser, game state machine, saturating score and prioritised beeper requests.
module game_flow_ctrl #(
    parameter int DIE_FRAMES        = 30,
    parameter int OVER_HOLD_FRAMES  = 120,
    parameter int BEEP_FLAP_FRAMES  = 4,
    parameter int BEEP_SCORE_FRAMES = 8,
    parameter int BEEP_DIE_FRAMES   = 30,
    parameter int SCORE_MAX         = 999999
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        vsync,
    input  logic        key_n,
    input  logic        hit,
    input  logic        pass,
    output logic [1:0]  state,
    output logic        frame_tick,
    output logic        run_en,
    output logic        world_rst,
    output logic        flap,
    output logic [19:0] score,
    output logic        is_gameover,
    output logic        beep_req
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_DYING = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [1:0] P_NONE  = 2'd0;
    localparam logic [1:0] P_FLAP  = 2'd1;
    localparam logic [1:0] P_SCORE = 2'd2;
    localparam logic [1:0] P_DIE   = 2'd3;

    localparam int FCNT_MAX = (DIE_FRAMES > OVER_HOLD_FRAMES) ? DIE_FRAMES : OVER_HOLD_FRAMES;
    localparam int FCNT_W   = $clog2(FCNT_MAX + 1);
    localparam int BEEP_M1  = (BEEP_FLAP_FRAMES > BEEP_SCORE_FRAMES) ? BEEP_FLAP_FRAMES
                                                                     : BEEP_SCORE_FRAMES;
    localparam int BEEP_MAX = (BEEP_M1 > BEEP_DIE_FRAMES) ? BEEP_M1 : BEEP_DIE_FRAMES;
    localparam int BEEP_W   = $clog2(BEEP_MAX + 1);

    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] DIE_LAST   = FCNT_W'(DIE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] HOLD_DONE  = FCNT_W'(OVER_HOLD_FRAMES);
    localparam logic [BEEP_W-1:0] BEEP_ONE   = BEEP_W'(1);
    localparam logic [BEEP_W-1:0] LEN_FLAP   = BEEP_W'(BEEP_FLAP_FRAMES);
    localparam logic [BEEP_W-1:0] LEN_SCORE  = BEEP_W'(BEEP_SCORE_FRAMES);
    localparam logic [BEEP_W-1:0] LEN_DIE    = BEEP_W'(BEEP_DIE_FRAMES);
    localparam logic [19:0]       SCORE_LIM  = 20'(SCORE_MAX);

    // Input conditioning
    logic key_meta_q, key_sync_q, key_prev_q, press_q;
    logic vs_q, vs_prev_q, frame_tick_q;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta_q   <= 1'b0;
            key_sync_q   <= 1'b0;
            key_prev_q   <= 1'b0;
            press_q      <= 1'b0;
            vs_q         <= 1'b0;
            vs_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            key_meta_q   <= key_n;
            key_sync_q   <= key_meta_q;
            key_prev_q   <= key_sync_q;
            press_q      <= key_prev_q & ~key_sync_q;
            vs_q         <= vsync;
            vs_prev_q    <= vs_q;
            frame_tick_q <= vs_q & ~vs_prev_q;
        end
    end

    // Game state machine
    logic [1:0]        state_q, state_d;
    logic [19:0]       score_q, score_d;
    logic              hit_latch_q, hit_latch_d;
    logic              flap_pend_q, flap_pend_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              world_rst_q, world_rst_d;
    logic              flap_fire;
    logic              die_req, score_req, flap_req;

    // A flap is served combinationally so it coincides with the frame tick itself.
    assign flap_fire = (state_q == S_PLAY) & frame_tick_q & flap_pend_q & ~hit_latch_q;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        hit_latch_d = hit_latch_q;
        flap_pend_d = flap_pend_q;
        fcnt_d      = fcnt_q;
        world_rst_d = 1'b0;
        die_req     = 1'b0;
        score_req   = 1'b0;
        flap_req    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d     = S_PLAY;
                    world_rst_d = 1'b1;
                    score_d     = '0;
                    hit_latch_d = 1'b0;
                    flap_pend_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (hit) hit_latch_d = 1'b1;
                if (pass) begin
                    score_req = 1'b1;
                    if (score_q < SCORE_LIM) score_d = score_q + 20'd1;
                end
                if (frame_tick_q && hit_latch_q) begin
                    state_d     = S_DYING;
                    die_req     = 1'b1;
                    flap_pend_d = 1'b0;
                    fcnt_d      = '0;
                end else begin
                    if (flap_fire) begin
                        flap_req    = 1'b1;
                        flap_pend_d = 1'b0;
                    end
                    // A press on the serving tick queues for the following tick.
                    if (press_q) flap_pend_d = 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick_q) begin
                    if (fcnt_q == DIE_LAST) begin
                        state_d = S_OVER;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_ONE;
                    end
                end
            end
            S_OVER: begin
                if (press_q && fcnt_q == HOLD_DONE) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else if (frame_tick_q && fcnt_q != HOLD_DONE) begin
                    fcnt_d = fcnt_q + FCNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            hit_latch_q <= 1'b0;
            flap_pend_q <= 1'b0;
            fcnt_q      <= '0;
            world_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            hit_latch_q <= hit_latch_d;
            flap_pend_q <= flap_pend_d;
            fcnt_q      <= fcnt_d;
            world_rst_q <= world_rst_d;
        end
    end

    // Beeper arbitration: equal or higher priority restarts the sound
    logic [1:0]        req_prio;
    logic [BEEP_W-1:0] req_len;
    logic [1:0]        beep_prio_q, beep_prio_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              beep_q, beep_d;

    always_comb begin
        req_prio = P_NONE;
        req_len  = '0;
        if (die_req) begin
            req_prio = P_DIE;
            req_len  = LEN_DIE;
        end else if (score_req) begin
            req_prio = P_SCORE;
            req_len  = LEN_SCORE;
        end else if (flap_req) begin
            req_prio = P_FLAP;
            req_len  = LEN_FLAP;
        end
        beep_prio_d = beep_prio_q;
        beep_cnt_d  = beep_cnt_q;
        beep_d      = beep_q;
        if (req_prio != P_NONE && req_prio >= beep_prio_q) begin
            beep_prio_d = req_prio;
            beep_cnt_d  = req_len;
            beep_d      = 1'b1;
        end else if (frame_tick_q && beep_q) begin
            beep_cnt_d = beep_cnt_q - BEEP_ONE;
            if (beep_cnt_q == BEEP_ONE) begin
                beep_d      = 1'b0;
                beep_prio_d = P_NONE;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beep_prio_q <= P_NONE;
            beep_cnt_q  <= '0;
            beep_q      <= 1'b0;
        end else begin
            beep_prio_q <= beep_prio_d;
            beep_cnt_q  <= beep_cnt_d;
            beep_q      <= beep_d;
        end
    end

    assign state       = state_q;
    assign frame_tick  = frame_tick_q;
    assign run_en      = (state_q == S_PLAY);
    assign world_rst   = world_rst_q;
    assign flap        = flap_fire;
    assign score       = score_q;
    assign is_gameover = (state_q == S_OVER);
    assign beep_req    = beep_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomised bench for game_flow_ctrl against a per-cycle behavioural reference model.
module tb_game_flow_ctrl;

    localparam int FRAME  = 20;
    localparam int SMAX   = 15;
    localparam int DIE    = 30;
    localparam int HOLD   = 120;
    localparam int BFLAP  = 4;
    localparam int BSCORE = 8;
    localparam int BDIE   = 30;
    localparam int IDLE = 0, PLAY = 1, DYING = 2, OVER = 3;

    logic        vga_clk;
    logic        sys_rst_n, vsync, key_n, hit, pass;
    logic [1:0]  state;
    logic        frame_tick, run_en, world_rst, flap, is_gameover, beep_req;
    logic [19:0] score;

    game_flow_ctrl #(
        .DIE_FRAMES       (DIE),
        .OVER_HOLD_FRAMES (HOLD),
        .BEEP_FLAP_FRAMES (BFLAP),
        .BEEP_SCORE_FRAMES(BSCORE),
        .BEEP_DIE_FRAMES  (BDIE),
        .SCORE_MAX        (SMAX)
    ) dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .vsync      (vsync),
        .key_n      (key_n),
        .hit        (hit),
        .pass       (pass),
        .state      (state),
        .frame_tick (frame_tick),
        .run_en     (run_en),
        .world_rst  (world_rst),
        .flap       (flap),
        .score      (score),
        .is_gameover(is_gameover),
        .beep_req   (beep_req)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    int n_total = 0;
    int n_bad   = 0;
    bit abort   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
            if (n_bad >= 20) abort = 1'b1;
        end
    endtask

    // Reference model: pin histories (index 0 = latest sampled value) plus game bookkeeping
    bit vs_h [3];
    bit key_h[4];
    int m_state, m_score, m_ticks, m_beep_left, m_beep_prio;
    bit m_hit, m_pend, m_wrst;

    // Stimulus knobs, probabilities in per-mille per cycle
    int frame_pos, key_hold, p_press, p_hit, p_pass;
    bit hold_rst;

    task automatic model_reset();
        m_state = IDLE; m_score = 0; m_ticks = 0; m_beep_left = 0; m_beep_prio = 0;
        m_hit = 1'b0; m_pend = 1'b0; m_wrst = 1'b0;
        for (int i = 0; i < 3; i++) vs_h[i] = 1'b0;
        for (int i = 0; i < 4; i++) key_h[i] = 1'b0;
    endtask

    function automatic bit tick_now();
        return vs_h[1] && !vs_h[2];
    endfunction

    function automatic bit press_now();
        return key_h[3] && !key_h[2];
    endfunction

    task automatic check_outputs();
        bit tk;
        tk = tick_now();
        check_val("state",       state,       m_state);
        check_val("frame_tick",  frame_tick,  int'(tk));
        check_val("run_en",      run_en,      int'(m_state == PLAY));
        check_val("world_rst",   world_rst,   int'(m_wrst));
        check_val("flap",        flap,        int'(m_state == PLAY && tk && m_pend && !m_hit));
        check_val("score",       score,       m_score);
        check_val("is_gameover", is_gameover, int'(m_state == OVER));
        check_val("beep_req",    beep_req,    int'(m_beep_left > 0));
    endtask

    task automatic drive_inputs();
        sys_rst_n = !hold_rst;
        frame_pos = (frame_pos + 1) % FRAME;
        vsync     = (frame_pos < 3);
        if (key_hold > 0) begin
            key_hold--;
            key_n = 1'b0;
        end else begin
            key_n = 1'b1;
            if ($urandom_range(999) < p_press) key_hold = $urandom_range(5, 1);
        end
        hit  = ($urandom_range(999) < p_hit);
        pass = ($urandom_range(999) < p_pass);
    endtask

    // Advance the model across the coming clock edge using this cycle's tick/press.
    task automatic model_advance();
        bit tk, pr, old_hit;
        int req;
        if (!sys_rst_n) begin
            model_reset();
        end else begin
            tk = tick_now();
            pr = press_now();
            req = 0;
            m_wrst = 1'b0;
            case (m_state)
                IDLE: if (pr) begin
                    m_state = PLAY; m_wrst = 1'b1; m_score = 0; m_hit = 1'b0; m_pend = 1'b0;
                end
                PLAY: begin
                    old_hit = m_hit;
                    if (pass) begin
                        if (m_score < SMAX) m_score++;
                        req = 2;
                    end
                    if (tk && old_hit) begin
                        m_state = DYING; req = 3; m_pend = 1'b0; m_ticks = 0;
                    end else begin
                        if (tk && m_pend) begin
                            m_pend = 1'b0;
                            if (req < 1) req = 1;
                        end
                        if (pr) m_pend = 1'b1;
                    end
                    if (hit) m_hit = 1'b1;
                end
                DYING: if (tk) begin
                    m_ticks++;
                    if (m_ticks == DIE) begin m_state = OVER; m_ticks = 0; end
                end
                default: begin
                    if (pr && m_ticks >= HOLD) m_state = IDLE;
                    else if (tk) m_ticks++;
                end
            endcase
            if (req != 0 && req >= m_beep_prio) begin
                m_beep_prio = req;
                m_beep_left = (req == 3) ? BDIE : (req == 2) ? BSCORE : BFLAP;
            end else if (tk && m_beep_left > 0) begin
                m_beep_left--;
                if (m_beep_left == 0) m_beep_prio = 0;
            end
            vs_h[2] = vs_h[1]; vs_h[1] = vs_h[0]; vs_h[0] = vsync;
            key_h[3] = key_h[2]; key_h[2] = key_h[1]; key_h[1] = key_h[0]; key_h[0] = key_n;
        end
    endtask

    task automatic cycle();
        if (!abort) begin
            @(negedge vga_clk);
            check_outputs();
            drive_inputs();
            model_advance();
        end
    endtask

    task automatic wait_state(input int s, input int limit, input string tag);
        int n;
        n = 0;
        while (state !== 2'(s) && n < limit && !abort) begin
            cycle();
            n++;
        end
        check_val(tag, state, s);
    endtask

    initial begin
        sys_rst_n = 1'b0; vsync = 1'b0; key_n = 1'b1; hit = 1'b0; pass = 1'b0;
        frame_pos = 0; key_hold = 0; p_press = 0; p_hit = 0; p_pass = 0;
        hold_rst = 1'b1;
        model_reset();
        repeat (4) cycle();
        hold_rst = 1'b0;

        // Idle: hit and pass must be ignored
        p_hit = 50; p_pass = 50;
        repeat (60) cycle();

        // Start and play without collisions; score reaches saturation
        p_press = 15; p_hit = 0; p_pass = 30;
        wait_state(PLAY, 400, "start_play");
        repeat (40 * FRAME) cycle();

        // Full games: die, wait out DYING and the OVER hold, restart
        for (int g = 0; g < 3; g++) begin
            p_press = 20; p_hit = 3; p_pass = 30;
            wait_state(DYING, 6000, "reach_dying");
            p_hit = 50;
            wait_state(OVER, 1000, "reach_over");
            p_press = 10;
            wait_state(IDLE, 4000, "leave_over");
            wait_state(PLAY, 3000, "restart");
        end

        // Asynchronous reset while dying
        p_press = 20; p_hit = 20; p_pass = 30;
        wait_state(DYING, 3000, "reach_dying_rst");
        repeat (5) cycle();
        if (!abort) begin
            #7;
            sys_rst_n = 1'b0;
            hold_rst  = 1'b1;
            #1;
            check_val("arst_state",     state,       0);
            check_val("arst_score",     score,       0);
            check_val("arst_beep",      beep_req,    0);
            check_val("arst_world_rst", world_rst,   0);
            check_val("arst_gameover",  is_gameover, 0);
            check_val("arst_tick",      frame_tick,  0);
            model_reset();
        end
        repeat (3) cycle();
        hold_rst = 1'b0;
        p_hit = 5;
        wait_state(PLAY, 3000, "post_rst_play");
        repeat (200) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
